// File: rtl/button_press_arbiter.sv
// Latches per-button press pulses, offers them one at a time by fixed priority
// (lowest index first) over valid/ready, and enforces a lockout after each accept.
module button_press_arbiter #(
  parameter int unsigned N_BUTTONS      = 4,
  parameter int unsigned LOCKOUT_CYCLES = 1000,
  parameter int unsigned IDX_W          = $clog2(N_BUTTONS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [N_BUTTONS-1:0] press_pulse,
  output logic                 press_valid,
  output logic [IDX_W-1:0]     press_idx,
  input  logic                 press_ready,
  output logic                 busy,
  output logic                 dropped
);

  localparam int unsigned CntW = $clog2(LOCKOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StOffer, StLockout} state_e;

  state_e               state_q;
  logic [N_BUTTONS-1:0] pending_q;
  logic [CntW-1:0]      cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 dropped_q;

  logic [IDX_W-1:0]     sel_idx;
  logic [N_BUTTONS-1:0] sel_mask;
  logic [N_BUTTONS-1:0] set_mask;
  logic [N_BUTTONS-1:0] clr_mask;
  logic                 load;
  logic                 drop_cause;

  // Descending scan so the lowest set index is the one left standing.
  always_comb begin
    sel_idx  = '0;
    sel_mask = '0;
    for (int i = N_BUTTONS - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        sel_idx     = IDX_W'(i);
        sel_mask    = '0;
        sel_mask[i] = 1'b1;
      end
    end
  end

  always_comb begin
    load     = enable && (state_q == StIdle) && (|pending_q);
    clr_mask = load ? sel_mask : '0;
    set_mask = (enable && (state_q != StLockout)) ? press_pulse : '0;
    // A pulse on a bit being cleared this cycle re-arms it rather than dropping.
    drop_cause = enable && (((state_q == StLockout) && (|press_pulse)) ||
                            (|(press_pulse & pending_q & ~clr_mask)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pending_q <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      dropped_q <= 1'b0;
    end else begin
      dropped_q <= drop_cause;
      if (!enable) begin
        state_q   <= StIdle;
        pending_q <= '0;
        cnt_q     <= '0;
      end else begin
        pending_q <= (pending_q & ~clr_mask) | set_mask;
        unique case (state_q)
          StIdle: begin
            if (load) begin
              idx_q   <= sel_idx;
              state_q <= StOffer;
            end
          end
          StOffer: begin
            if (press_ready) begin
              cnt_q   <= CntW'(LOCKOUT_CYCLES);
              state_q <= StLockout;
            end
          end
          StLockout: begin
            cnt_q <= cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
              state_q <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign press_valid = (state_q == StOffer);
  assign busy        = (state_q != StIdle);
  assign press_idx   = idx_q;
  assign dropped     = dropped_q;

endmodule

// File: tb/tb_button_press_arbiter.sv
// Directed bench for button_press_arbiter with LOCKOUT_CYCLES=4 and four buttons.
module tb_button_press_arbiter;

  localparam int unsigned NB = 4;
  localparam int unsigned LC = 4;
  localparam int unsigned IW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [NB-1:0] press_pulse;
  logic          press_valid;
  logic [IW-1:0] press_idx;
  logic          press_ready;
  logic          busy;
  logic          dropped;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_press_arbiter #(
    .N_BUTTONS     (NB),
    .LOCKOUT_CYCLES(LC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .press_pulse(press_pulse),
    .press_valid(press_valid),
    .press_idx  (press_idx),
    .press_ready(press_ready),
    .busy       (busy),
    .dropped    (dropped)
  );

  // Each call lands 1 time unit after a rising edge, i.e. at the start of a new cycle.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_idx(input string tag, input logic [IW-1:0] obs,
                           input logic [IW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    enable      = 1'b0;
    press_pulse = '0;
    press_ready = 1'b0;
    step(2);
    check_bit("rst_valid", press_valid, 1'b0);
    check_idx("rst_idx", press_idx, 2'd0);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_dropped", dropped, 1'b0);
    rst_n  = 1'b1;
    enable = 1'b1;
    step(1);

    // Single press on button 2, ready held high.
    press_ready = 1'b1;
    press_pulse = 4'b0100;
    step(1);
    press_pulse = '0;
    check_bit("single_t1_valid", press_valid, 1'b0);
    check_bit("single_t1_busy", busy, 1'b0);
    step(1);
    check_bit("single_t2_valid", press_valid, 1'b1);
    check_idx("single_t2_idx", press_idx, 2'd2);
    check_bit("single_t2_busy", busy, 1'b1);
    for (int i = 3; i <= 6; i++) begin
      step(1);
      check_bit("single_lock_busy", busy, 1'b1);
      check_bit("single_lock_valid", press_valid, 1'b0);
    end
    step(1);
    check_bit("single_t7_busy", busy, 1'b0);
    check_bit("single_t7_valid", press_valid, 1'b0);

    // Priority: buttons 1 and 3 together.
    press_pulse = 4'b1010;
    step(1);
    press_pulse = '0;
    step(1);
    check_bit("prio_t2_valid", press_valid, 1'b1);
    check_idx("prio_t2_idx", press_idx, 2'd1);
    step(5);
    check_bit("prio_t7_busy", busy, 1'b0);
    step(1);
    check_bit("prio_t8_valid", press_valid, 1'b1);
    check_idx("prio_t8_idx", press_idx, 2'd3);
    step(5);
    check_bit("prio_t13_busy", busy, 1'b0);

    // Backpressure on button 3, with button 0 pressed during the offer.
    press_ready = 1'b0;
    press_pulse = 4'b1000;
    step(1);
    press_pulse = '0;
    step(1);
    check_bit("bp_t2_valid", press_valid, 1'b1);
    check_idx("bp_t2_idx", press_idx, 2'd3);
    press_pulse = 4'b0001;
    step(1);
    press_pulse = '0;
    check_bit("bp_t3_nodrop", dropped, 1'b0);
    for (int i = 3; i <= 11; i++) begin
      check_bit("bp_hold_valid", press_valid, 1'b1);
      check_idx("bp_hold_idx", press_idx, 2'd3);
      step(1);
    end
    check_bit("bp_t12_valid", press_valid, 1'b1);
    press_ready = 1'b1;
    step(1);
    press_ready = 1'b0;
    check_bit("bp_t13_valid", press_valid, 1'b0);
    check_bit("bp_t13_busy", busy, 1'b1);
    step(5);
    check_bit("bp_t18_valid", press_valid, 1'b1);
    check_idx("bp_t18_idx", press_idx, 2'd0);

    // Pulse during lockout is dropped and never offered.
    press_ready = 1'b1;
    step(1);
    press_pulse = 4'b0010;
    step(1);
    press_pulse = '0;
    check_bit("lock_drop", dropped, 1'b1);
    check_bit("lock_drop_busy", busy, 1'b1);
    step(1);
    check_bit("lock_drop_once", dropped, 1'b0);
    step(2);
    check_bit("lock_end_busy", busy, 1'b0);
    step(1);
    check_bit("lock_no_offer", press_valid, 1'b0);

    // Re-press of a button that is still pending is dropped.
    press_ready = 1'b0;
    press_pulse = 4'b0011;
    step(1);
    press_pulse = '0;
    step(1);
    check_bit("dup_offer_valid", press_valid, 1'b1);
    check_idx("dup_offer_idx", press_idx, 2'd0);
    press_pulse = 4'b0010;
    step(1);
    press_pulse = '0;
    check_bit("dup_drop", dropped, 1'b1);
    step(1);
    check_bit("dup_drop_once", dropped, 1'b0);

    // Flush with button 1 still pending: nothing offered after re-enable.
    enable = 1'b0;
    step(1);
    check_bit("flush1_valid", press_valid, 1'b0);
    check_bit("flush1_busy", busy, 1'b0);
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_bit("flush1_no_offer", press_valid, 1'b0);
    end

    // Flush while offering button 3 with buttons 0 and 2 pending.
    press_pulse = 4'b1000;
    step(1);
    press_pulse = '0;
    step(1);
    check_idx("flush2_idx", press_idx, 2'd3);
    press_pulse = 4'b0101;
    step(1);
    check_bit("flush2_valid_pre", press_valid, 1'b1);
    check_bit("flush2_nodrop", dropped, 1'b0);
    enable      = 1'b0;
    press_pulse = 4'b0001;
    step(1);
    press_pulse = '0;
    check_bit("flush2_valid", press_valid, 1'b0);
    check_bit("flush2_busy", busy, 1'b0);
    check_bit("flush2_disabled_nodrop", dropped, 1'b0);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check_bit("flush2_no_offer", press_valid, 1'b0);
    end

    // Reset during lockout with button 2 still pending.
    press_ready = 1'b1;
    press_pulse = 4'b0110;
    step(1);
    press_pulse = '0;
    step(1);
    check_idx("rst2_offer_idx", press_idx, 2'd1);
    step(1);
    check_bit("rst2_lock_busy", busy, 1'b1);
    rst_n = 1'b0;
    step(1);
    check_bit("rst2_valid", press_valid, 1'b0);
    check_bit("rst2_busy", busy, 1'b0);
    check_idx("rst2_idx", press_idx, 2'd0);
    check_bit("rst2_dropped", dropped, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check_bit("rst2_no_offer", press_valid, 1'b0);
    end
    press_pulse = 4'b1000;
    step(1);
    press_pulse = '0;
    step(1);
    check_bit("rst2_new_valid", press_valid, 1'b1);
    check_idx("rst2_new_idx", press_idx, 2'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_press_arbiter.md
# button_press_arbiter

Sits between the per-button synchronizer/edge-detect stages and the game FSM. Each button stage delivers a one-cycle press pulse. This block latches the pulses, shares the single "player input" channel among all buttons by fixed priority, and offers one press at a time over a valid/ready handshake. After each accepted press it enforces a lockout window, so bounce or double-taps after the synchronizer cannot register as extra moves.

## Interface
- N_BUTTONS, 4 — number of buttons (≥2).
- LOCKOUT_CYCLES, 1000 — lockout length in clk cycles after an accepted press (≥1).
- IDX_W, $clog2(N_BUTTONS) — derived index width; not overridden.

- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- enable  in  1  game is in player-input phase; low flushes the block.
- press_pulse  in  N_BUTTONS  one-cycle press pulses, already synchronous to clk.
- press_valid  out  1  a press is being offered.
- press_idx  out  IDX_W  button index of offered press; held stable while press_valid.
- press_ready  in  1  game FSM accepts offered press.
- busy  out  1  state ≠ IDLE.
- dropped  out  1  one-cycle pulse: a press was discarded.

## Operation
- Registers: pending[N_BUTTONS-1:0], state {IDLE, OFFER, LOCKOUT}, lockout counter of width $clog2(LOCKOUT_CYCLES+1), press_idx, dropped.
- Reset (rst_n=0 at a posedge): pending=0, state=IDLE, counter=0, press_valid=0, press_idx=0, dropped=0, busy=0.
- Pending latch:
  - With enable=1 and state ≠ LOCKOUT, press_pulse[i] sets pending[i].
  - Set wins over a same-cycle clear of the same bit.
- IDLE:
  - With enable=1 and pending≠0, select i = lowest set index.
  - Load press_idx=i, clear pending[i], go to OFFER.
- OFFER:
  - press_valid=1; press_idx is frozen.
  - New pulses, including for the offered button, continue to latch into pending.
  - press_valid && press_ready: load counter=LOCKOUT_CYCLES, go to LOCKOUT.
- LOCKOUT:
  - Counter decrements each cycle.
  - When counter==1, next state is IDLE.
  - All press_pulse bits are discarded; pending bits captured earlier are kept.
- enable=0 (any state, overrides all transitions):
  - Next state IDLE; pending cleared; counter cleared.
  - press_valid deasserts on the next cycle; the offer is withdrawn, not accepted.
  - Pulses are ignored and are not counted as dropped.
- dropped (registered, asserted the cycle after the cause) fires when enable=1 and either:
  - a pulse arrives in LOCKOUT, or
  - a pulse arrives for a bit already pending that is not being cleared that cycle.
- Multiple causes in one cycle produce a single dropped pulse.

## Timing
- Press latency: pulse at cycle t → pending visible at t+1 → press_valid=1 at t+2 (from IDLE, enable=1).
- Handshake: accept occurs on a cycle with valid&&ready. press_valid=0 from the next cycle through the end of lockout.
- Lockout: accept at cycle k → LOCKOUT during cycles k+1 … k+LOCKOUT_CYCLES → IDLE at k+LOCKOUT_CYCLES+1.
- Earliest next valid after lockout: k+LOCKOUT_CYCLES+2.
- press_ready while press_valid=0 has no effect.
- Simultaneous pulses on several buttons: all latch; they are offered one per handshake, in ascending index order.
- Reset mid-offer or mid-lockout: all outputs return to reset values at the next cycle.
- busy is combinational from state; press_valid equals (state==OFFER).

## Test plan
- Single press: LOCKOUT_CYCLES=4, enable=1, press_pulse=4'b0100 at t=0, press_ready held 1 → press_valid=1, press_idx=2 at t=2; busy 1 during t=2..6; IDLE at t=7.
- Priority: press_pulse=4'b1010 at t=0, ready=1 → idx 1 accepted at t=2. Then idx 3 is offered with press_valid=1 at t=2+4+2=8.
- Backpressure: press_ready=0 for 10 cycles after valid → press_idx stable and press_valid held. Pulse on button 0 during the offer → offered after lockout.
- Drops: pulse on button 1 during LOCKOUT → dropped=1 for exactly one cycle, no later offer. Second pulse on an already-pending button → dropped=1.
- Enable flush: offer of idx 3 pending with 2 more pending bits, enable→0 → press_valid=0 next cycle, busy=0, pending empty. Re-enable with no pulses → no offer.
- Reset: rst_n=0 during LOCKOUT with pending≠0 → all outputs 0 next cycle; no offer after rst_n=1 until a new pulse.
